// File: rtl/knn_dist_sorter.sv
// knn_dist_sorter: squared-distance pipeline feeding a sorted K-nearest list.
// Three stages per beat: coordinate difference, squared sum, sorted insertion.
module knn_dist_sorter #(
    parameter int WDATA_W = 32,
    parameter int K       = 4,
    parameter int IDX_W   = 7,
    parameter int DIST_W  = 34
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                KNN_START_I,
    input  logic [WDATA_W-1:0]  KNN_TEST_PT_I,
    input  logic [WDATA_W-1:0]  KNN_DATA_PT_I,
    output logic                KNN_DONE_O,
    output logic [K*DIST_W-1:0] KNN_NEIGH_DIST_O,
    output logic [K*IDX_W-1:0]  KNN_NEIGH_IDX_O,
    output logic [4:0]          KNN_NEIGH_CNT_O,
    output logic                KNN_DROP_O
);

    localparam int HW  = WDATA_W / 2;
    localparam int DW  = HW + 1;
    localparam int EXT = DIST_W - DW;

    if (DIST_W != WDATA_W + 2 || K < 1 || K > 16) begin : g_param_chk
        $error("knn_dist_sorter: DIST_W must be WDATA_W+2 and K in 1..16");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  beat_q;
    logic              done_q;
    logic              drop_q;

    logic              first;
    logic              take;

    logic              s1_vld_q;
    logic [IDX_W-1:0]  s1_idx_q;
    logic [DW-1:0]     dx_q;
    logic [DW-1:0]     dy_q;
    logic [DW-1:0]     dx_d;
    logic [DW-1:0]     dy_d;

    logic              s2_vld_q;
    logic [IDX_W-1:0]  s2_idx_q;
    logic [DIST_W-1:0] s2_dist_q;
    logic [DIST_W-1:0] dx_ext;
    logic [DIST_W-1:0] dy_ext;
    logic [DIST_W-1:0] dist_d;

    logic [DIST_W-1:0] list_dist_q [K];
    logic [IDX_W-1:0]  list_idx_q  [K];
    logic [DIST_W-1:0] list_dist_d [K];
    logic [IDX_W-1:0]  list_idx_d  [K];
    logic [K-1:0]      gt;
    logic              prev_gt;
    logic [4:0]        cnt_q;

    // first beat of a run clears the list; only IDLE/ACCUM beats enter the pipe
    assign first = KNN_START_I && (state_q == IDLE);
    assign take  = KNN_START_I && (state_q == IDLE || state_q == ACCUM);

    // run control: beat counter, end-of-run sequencing, done/drop pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            done_q <= (state_q == DRAIN);
            drop_q <= KNN_START_I && (state_q == DRAIN || state_q == DONE);
            unique case (state_q)
                IDLE: begin
                    if (KNN_START_I) begin
                        state_q <= ACCUM;
                        beat_q  <= IDX_W'(1);
                    end
                end
                ACCUM: begin
                    if (KNN_START_I) begin
                        beat_q <= beat_q + 1'b1;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN:   state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // coordinates sign-extended by one bit so the difference cannot wrap
    assign dx_d = {KNN_DATA_PT_I[WDATA_W-1], KNN_DATA_PT_I[WDATA_W-1:HW]}
                - {KNN_TEST_PT_I[WDATA_W-1], KNN_TEST_PT_I[WDATA_W-1:HW]};
    assign dy_d = {KNN_DATA_PT_I[HW-1], KNN_DATA_PT_I[HW-1:0]}
                - {KNN_TEST_PT_I[HW-1], KNN_TEST_PT_I[HW-1:0]};

    // full-width two's complement square; low DIST_W bits hold the exact value
    assign dx_ext = {{EXT{dx_q[DW-1]}}, dx_q};
    assign dy_ext = {{EXT{dy_q[DW-1]}}, dy_q};
    assign dist_d = dx_ext * dx_ext + dy_ext * dy_ext;

    // stage 1 and stage 2 pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_idx_q  <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            s2_vld_q  <= 1'b0;
            s2_idx_q  <= '0;
            s2_dist_q <= '0;
        end else begin
            s1_vld_q  <= take;
            s1_idx_q  <= first ? '0 : beat_q;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            s2_vld_q  <= s1_vld_q;
            s2_idx_q  <= s1_idx_q;
            s2_dist_q <= dist_d;
        end
    end

    // sorted list keeps gt thermometer-shaped; the new entry lands at its first 1
    always_comb begin
        prev_gt = 1'b0;
        for (int i = 0; i < K; i++) begin
            gt[i]          = list_dist_q[i] > s2_dist_q;
            list_dist_d[i] = list_dist_q[i];
            list_idx_d[i]  = list_idx_q[i];
        end
        for (int i = 1; i < K; i++) begin
            if (gt[i] && gt[i-1]) begin
                list_dist_d[i] = list_dist_q[i-1];
                list_idx_d[i]  = list_idx_q[i-1];
            end
        end
        for (int i = 0; i < K; i++) begin
            if (gt[i] && !prev_gt) begin
                list_dist_d[i] = s2_dist_q;
                list_idx_d[i]  = s2_idx_q;
            end
            prev_gt = gt[i];
        end
    end

    // stage 3: list update, cleared at the start of every run
    always_ff @(posedge clk) begin
        if (rst || first) begin
            for (int i = 0; i < K; i++) begin
                list_dist_q[i] <= '1;
                list_idx_q[i]  <= '0;
            end
            cnt_q <= '0;
        end else if (s2_vld_q) begin
            for (int i = 0; i < K; i++) begin
                list_dist_q[i] <= list_dist_d[i];
                list_idx_q[i]  <= list_idx_d[i];
            end
            if (cnt_q != 5'(K)) begin
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_pack
        assign KNN_NEIGH_DIST_O[g*DIST_W +: DIST_W] = list_dist_q[g];
        assign KNN_NEIGH_IDX_O[g*IDX_W +: IDX_W]    = list_idx_q[g];
    end

    assign KNN_NEIGH_CNT_O = cnt_q;
    assign KNN_DONE_O      = done_q;
    assign KNN_DROP_O      = drop_q;

endmodule

// File: tb/tb_knn_dist_sorter.sv
// tb_knn_dist_sorter: directed and random streams checked each cycle against
// a top-K-by-stable-sort reference model of the neighbour list.
module tb_knn_dist_sorter;

    localparam int WDATA_W = 32;
    localparam int K       = 4;
    localparam int IDX_W   = 7;
    localparam int DIST_W  = 34;
    localparam int CW      = K * DIST_W;
    localparam longint ONES = 64'h3_FFFF_FFFF;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [WDATA_W-1:0]  tpt;
    logic [WDATA_W-1:0]  dpt;
    logic                done_o;
    logic [CW-1:0]       dist_o;
    logic [K*IDX_W-1:0]  idx_o;
    logic [4:0]          cnt_o;
    logic                drop_o;

    knn_dist_sorter #(
        .WDATA_W(WDATA_W),
        .K      (K),
        .IDX_W  (IDX_W),
        .DIST_W (DIST_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .KNN_START_I     (start),
        .KNN_TEST_PT_I   (tpt),
        .KNN_DATA_PT_I   (dpt),
        .KNN_DONE_O      (done_o),
        .KNN_NEIGH_DIST_O(dist_o),
        .KNN_NEIGH_IDX_O (idx_o),
        .KNN_NEIGH_CNT_O (cnt_o),
        .KNN_DROP_O      (drop_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [CW-1:0] got, logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
        end
    endtask

    // reference model: every processed beat of the current run, in arrival order
    longint q_dist[$];
    int     q_idx[$];
    int     q_edge[$];
    int     cur_edge = 0;
    int     seq      = 0;
    int     end_ctr  = 0;
    bit     in_run   = 0;
    bit     m_done   = 0;
    bit     m_drop   = 0;

    function automatic longint sx(logic [15:0] v);
        return longint'($signed(v));
    endfunction

    task automatic push_beat();
        longint dx;
        longint dy;
        dx = sx(dpt[31:16]) - sx(tpt[31:16]);
        dy = sx(dpt[15:0]) - sx(tpt[15:0]);
        q_dist.push_back(dx * dx + dy * dy);
        q_idx.push_back(seq % (1 << IDX_W));
        q_edge.push_back(cur_edge);
        seq++;
    endtask

    task automatic model_step();
        cur_edge++;
        m_done = 0;
        m_drop = 0;
        if (rst) begin
            q_dist.delete();
            q_idx.delete();
            q_edge.delete();
            in_run  = 0;
            end_ctr = 0;
            seq     = 0;
        end else if (end_ctr == 1) begin
            m_done  = 1;
            m_drop  = start;
            end_ctr = 2;
        end else if (end_ctr == 2) begin
            m_drop  = start;
            end_ctr = 0;
        end else if (in_run) begin
            if (start) begin
                push_beat();
            end else begin
                in_run  = 0;
                end_ctr = 1;
            end
        end else if (start) begin
            q_dist.delete();
            q_idx.delete();
            q_edge.delete();
            seq    = 0;
            in_run = 1;
            push_beat();
        end
    endtask

    // K smallest of the beats that have reached the list, earliest first on ties
    task automatic model_list(output logic [CW-1:0] ed,
                              output logic [K*IDX_W-1:0] ei,
                              output int cnt);
        bit used[];
        used = new[q_dist.size()];
        ed   = '1;
        ei   = '0;
        cnt  = 0;
        for (int k = 0; k < K; k++) begin
            int best;
            best = -1;
            for (int j = 0; j < q_dist.size(); j++) begin
                if (!used[j] && q_edge[j] + 2 <= cur_edge &&
                    (best < 0 || q_dist[j] < q_dist[best])) begin
                    best = j;
                end
            end
            if (best >= 0) begin
                used[best] = 1;
                ed[k*DIST_W +: DIST_W] = DIST_W'(q_dist[best]);
                ei[k*IDX_W +: IDX_W]   = IDX_W'(q_idx[best]);
                cnt++;
            end
        end
    endtask

    // per-cycle compare against the model
    initial begin
        logic [CW-1:0]      ed;
        logic [K*IDX_W-1:0] ei;
        int                 c;
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            model_list(ed, ei, c);
            chk("done", CW'(done_o), CW'(m_done));
            chk("drop", CW'(drop_o), CW'(m_drop));
            chk("cnt", CW'(cnt_o), CW'(c));
            chk("dist", dist_o, ed);
            chk("idx", CW'(idx_o), CW'(ei));
        end
    end

    task automatic step(bit s, int xt, int yt, int xd, int yd);
        start = s;
        tpt   = {xt[15:0], yt[15:0]};
        dpt   = {xd[15:0], yd[15:0]};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    task automatic chk_list(string nm,
                            longint d0, longint d1, longint d2, longint d3,
                            int i0, int i1, int i2, int i3, int c);
        logic [CW-1:0]      ed;
        logic [K*IDX_W-1:0] ei;
        ed = {DIST_W'(d3), DIST_W'(d2), DIST_W'(d1), DIST_W'(d0)};
        ei = {IDX_W'(i3), IDX_W'(i2), IDX_W'(i1), IDX_W'(i0)};
        chk({nm, "_dist"}, dist_o, ed);
        chk({nm, "_idx"}, CW'(idx_o), CW'(ei));
        chk({nm, "_cnt"}, CW'(cnt_o), CW'(c));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        tpt   = '0;
        dpt   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_list("reset", ONES, ONES, ONES, ONES, 0, 0, 0, 0, 0);
        chk("reset_done", CW'(done_o), CW'(0));

        // basic six-beat run
        step(1, 0, 0, 3, 4);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 0, 2);
        step(1, 0, 0, 5, 0);
        step(1, 0, 0, -1, -1);
        step(1, 0, 0, 2, 2);
        idle(2);
        chk("t1_done", CW'(done_o), CW'(1));
        chk_list("t1", 2, 2, 4, 8, 1, 4, 2, 5, 4);
        idle(3);

        // short run
        step(1, 0, 0, 0, 3);
        step(1, 0, 0, 1, 0);
        idle(2);
        chk("t2_done", CW'(done_o), CW'(1));
        chk_list("t2", 1, 9, ONES, ONES, 1, 0, 0, 0, 2);
        idle(3);

        // extreme coordinates
        step(1, -32768, -32768, 32767, 32767);
        idle(2);
        chk_list("t3", 64'd8589672450, ONES, ONES, ONES, 0, 0, 0, 0, 1);
        idle(3);

        // beat in DRAIN is dropped; new run right after DONE
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 2, 0);
        step(1, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("t4_done", CW'(done_o), CW'(1));
        chk("t4_drop", CW'(drop_o), CW'(1));
        chk_list("t4a", 1, 4, 9, ONES, 0, 1, 2, 0, 3);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 3, 0);
        step(1, 0, 0, 0, 1);
        idle(2);
        chk("t4b_done", CW'(done_o), CW'(1));
        chk_list("t4b", 1, 9, ONES, ONES, 1, 0, 0, 0, 2);
        idle(3);

        // reset mid-run
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 2);
        step(1, 0, 0, 2, 2);
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        chk_list("t5_rst", ONES, ONES, ONES, ONES, 0, 0, 0, 0, 0);
        chk("t5_done", CW'(done_o), CW'(0));
        idle(4);
        step(1, 0, 0, 2, 1);
        idle(2);
        chk("t5b_done", CW'(done_o), CW'(1));
        chk_list("t5b", 5, ONES, ONES, ONES, 0, 0, 0, 0, 1);
        idle(3);

        // index wrap
        for (int i = 0; i < 130; i++) begin
            if (i == 129) step(1, 0, 0, 1, 0);
            else          step(1, 0, 0, 1, 2);
        end
        idle(2);
        chk("t6_done", CW'(done_o), CW'(1));
        chk_list("t6", 1, 5, 5, 5, 1, 0, 1, 2, 4);
        idle(3);

        // random streams with gaps, drops and occasional resets
        for (int n = 0; n < 800; n++) begin
            int xt, yt, xd, yd;
            if ($urandom_range(0, 1) == 0) begin
                xt = int'($urandom_range(0, 6)) - 3;
                yt = int'($urandom_range(0, 6)) - 3;
                xd = int'($urandom_range(0, 6)) - 3;
                yd = int'($urandom_range(0, 6)) - 3;
            end else begin
                xt = int'($urandom_range(0, 65535)) - 32768;
                yt = int'($urandom_range(0, 65535)) - 32768;
                xd = int'($urandom_range(0, 65535)) - 32768;
                yd = int'($urandom_range(0, 65535)) - 32768;
            end
            rst = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 3) != 0, xt, yt, xd, yd);
        end
        rst = 1'b0;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
